// File: rtl/rsnn_pkg.sv
// Shared definitions for the recurrent spiking neuron controller:
// register map, CTRL bit positions and the run-FSM state encoding.
package rsnn_pkg;

   localparam logic [2:0] ADDR_THR  = 3'd0;
   localparam logic [2:0] ADDR_DEC  = 3'd1;
   localparam logic [2:0] ADDR_REF  = 3'd2;
   localparam logic [2:0] ADDR_FBS  = 3'd3;
   localparam logic [2:0] ADDR_CTRL = 3'd4;
   localparam logic [2:0] ADDR_CUR  = 3'd5;

   localparam int CTRL_RUN      = 0;
   localparam int CTRL_SOFT_RST = 1;
   localparam int CTRL_COMMIT   = 2;

   // Neuron parameter slots, indexed by the low two address bits.
   localparam int NUM_PARAMS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RSTP = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/rsnn_spike_counter.sv
// Saturating event counter for neuron output spikes.
// clr wins over counting; counting only while en is high.
module rsnn_spike_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/rsnn_neuron_ctrl.sv
// Configuration and run sequencing for one recurrent spiking neuron.
// Byte-wide register port writes shadow parameters, input current and CTRL;
// shadow parameters reach the neuron only on commit or on neuron restart.
// Build option: RSNN_SPIKE_COUNT_EN adds the saturating spike counter,
// otherwise spike_count is tied to zero.
//
// state | meaning
// IDLE  | neuron held disabled, waiting for run
// RSTP  | neuron_reset pulse of RST_CYCLES cycles, writes stalled
// RUN   | neuron enabled and driven with the CUR register
module rsnn_neuron_ctrl
   import rsnn_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CNT_W      = 16,
   parameter int RST_CYCLES = 2,
   parameter int THR_INIT   = 50,
   parameter int DEC_INIT   = 10,
   parameter int REF_INIT   = 5,
   parameter int FBS_INIT   = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [2:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              spike_in,
   output logic              neuron_reset,
   output logic              neuron_enable,
   output logic [DATA_W-1:0] neuron_current,
   output logic [DATA_W-1:0] neuron_threshold,
   output logic [DATA_W-1:0] neuron_decay,
   output logic [DATA_W-1:0] neuron_refractory,
   output logic [DATA_W-1:0] neuron_feedback,
   output logic              running,
   output logic [CNT_W-1:0]  spike_count
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

   // Slot order matches the address map: 0 THR, 1 DEC, 2 REF, 3 FBS.
   localparam logic [NUM_PARAMS-1:0][DATA_W-1:0] PARAM_INIT = {
      DATA_W'(FBS_INIT), DATA_W'(REF_INIT), DATA_W'(DEC_INIT), DATA_W'(THR_INIT)
   };

   logic [NUM_PARAMS-1:0][DATA_W-1:0] shadow_q, shadow_d;
   logic [NUM_PARAMS-1:0][DATA_W-1:0] active_q, active_d;
   logic [DATA_W-1:0]                 cur_q, cur_d;
   logic                              run_q, run_d;

   state_t                            state_q, state_d;
   logic [RC_W-1:0]                   rst_cnt_q, rst_cnt_d;
   logic                              neuron_reset_q, neuron_reset_d;
   logic                              neuron_enable_q, neuron_enable_d;
   logic                              running_q, running_d;
   logic                              wr_ready_q, wr_ready_d;
   logic [DATA_W-1:0]                 neuron_current_q, neuron_current_d;

   logic                              wr_fire;
   logic                              soft_rst;
   logic                              commit;
   logic                              enter_rstp;

   assign wr_fire = wr_valid & wr_ready_q;

   // Register write decode; CTRL pulse bits exist only for the accepting cycle.
   always_comb begin
      shadow_d = shadow_q;
      cur_d    = cur_q;
      run_d    = run_q;
      soft_rst = 1'b0;
      commit   = 1'b0;
      if (wr_fire) begin
         case (wr_addr)
            ADDR_THR, ADDR_DEC, ADDR_REF, ADDR_FBS: shadow_d[wr_addr[1:0]] = wr_data;
            ADDR_CTRL: begin
               run_d    = wr_data[CTRL_RUN];
               soft_rst = wr_data[CTRL_SOFT_RST];
               commit   = wr_data[CTRL_COMMIT];
            end
            ADDR_CUR: cur_d = wr_data;
            default: ;
         endcase
      end
   end

   // Run FSM next state; soft reset re-arms the reset pulse from any state.
   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      enter_rstp = 1'b0;
      if (soft_rst) begin
         enter_rstp = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: if (run_d) enter_rstp = 1'b1;
            ST_RSTP: begin
               if (rst_cnt_q == '0) begin
                  state_d = run_q ? ST_RUN : ST_IDLE;
               end else begin
                  rst_cnt_d = rst_cnt_q - 1'b1;
               end
            end
            ST_RUN:  if (!run_d) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
      if (enter_rstp) begin
         state_d   = ST_RSTP;
         rst_cnt_d = RC_LOAD;
      end
   end

   // Active set takes the pre-write shadow set on commit or neuron restart.
   always_comb begin
      active_d = active_q;
      if (commit || enter_rstp) begin
         active_d = shadow_q;
      end
   end

   // Registered neuron-facing outputs derived from the upcoming state.
   always_comb begin
      neuron_reset_d   = (state_d == ST_RSTP);
      neuron_enable_d  = (state_d == ST_RUN);
      running_d        = (state_d == ST_RUN);
      wr_ready_d       = (state_d != ST_RSTP);
      neuron_current_d = (state_d == ST_RUN) ? cur_d : '0;
   end

   // Configuration registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= PARAM_INIT;
         active_q <= PARAM_INIT;
         cur_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         cur_q    <= cur_d;
         run_q    <= run_d;
      end
   end

   // Run FSM with its registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         rst_cnt_q        <= '0;
         neuron_reset_q   <= 1'b0;
         neuron_enable_q  <= 1'b0;
         running_q        <= 1'b0;
         wr_ready_q       <= 1'b1;
         neuron_current_q <= '0;
      end else begin
         state_q          <= state_d;
         rst_cnt_q        <= rst_cnt_d;
         neuron_reset_q   <= neuron_reset_d;
         neuron_enable_q  <= neuron_enable_d;
         running_q        <= running_d;
         wr_ready_q       <= wr_ready_d;
         neuron_current_q <= neuron_current_d;
      end
   end

   assign wr_ready          = wr_ready_q;
   assign neuron_reset      = neuron_reset_q;
   assign neuron_enable     = neuron_enable_q;
   assign running           = running_q;
   assign neuron_current    = neuron_current_q;
   assign neuron_threshold  = active_q[0];
   assign neuron_decay      = active_q[1];
   assign neuron_refractory = active_q[2];
   assign neuron_feedback   = active_q[3];

`ifdef RSNN_SPIKE_COUNT_EN
   rsnn_spike_counter #(
      .CNT_W (CNT_W)
   ) u_spike_counter (
      .clk (clk),
      .rst (reset),
      .en  (state_q == ST_RUN),
      .clr (enter_rstp),
      .inc (spike_in),
      .cnt (spike_count)
   );
`else
   logic unused_spike_in;
   assign unused_spike_in = spike_in;
   assign spike_count     = '0;
`endif

endmodule

// File: tb/tb_rsnn_neuron_ctrl.sv
// Bench for rsnn_neuron_ctrl: directed vector table, hand sequences for
// multi-cycle corners, then random traffic against a behavioural model.
module tb_rsnn_neuron_ctrl;

   localparam int CW  = 4;
   localparam int RC  = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [2:0]    wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          spike_in = 1'b0;
   logic          neuron_reset;
   logic          neuron_enable;
   logic [7:0]    neuron_current;
   logic [7:0]    neuron_threshold;
   logic [7:0]    neuron_decay;
   logic [7:0]    neuron_refractory;
   logic [7:0]    neuron_feedback;
   logic          running;
   logic [CW-1:0] spike_count;

   always #5 clk = ~clk;

   rsnn_neuron_ctrl #(
      .DATA_W     (8),
      .CNT_W      (CW),
      .RST_CYCLES (RC)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .wr_valid          (wr_valid),
      .wr_ready          (wr_ready),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .spike_in          (spike_in),
      .neuron_reset      (neuron_reset),
      .neuron_enable     (neuron_enable),
      .neuron_current    (neuron_current),
      .neuron_threshold  (neuron_threshold),
      .neuron_decay      (neuron_decay),
      .neuron_refractory (neuron_refractory),
      .neuron_feedback   (neuron_feedback),
      .running           (running),
      .spike_count       (spike_count)
   );

   int checks = 0;
   int failures = 0;

   // Behavioural model: mode 0 idle, 1 resetting neuron, 2 running.
   int init_v [4] = '{50, 10, 5, 20};
   int m_sh [4];
   int m_ac [4];
   int m_cur, m_run, m_mode, m_left, m_cnt;

`ifdef RSNN_SPIKE_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_sh[i] = init_v[i];
         m_ac[i] = init_v[i];
      end
      m_cur = 0; m_run = 0; m_mode = 0; m_left = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit v, input int a, input int d, input bit s);
      int  old_sh [4];
      bit  restart;
      bit  acc;
      for (int i = 0; i < 4; i++) old_sh[i] = m_sh[i];
      acc = v && (m_mode != 1);
      restart = 1'b0;
      if (m_mode == 2 && s && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (acc) begin
         if (a < 4) m_sh[a] = d;
         else if (a == 5) m_cur = d;
         else if (a == 4) begin
            m_run = d % 2;
            if ((d / 4) % 2 == 1) for (int i = 0; i < 4; i++) m_ac[i] = old_sh[i];
            if ((d / 2) % 2 == 1) restart = 1'b1;
         end
      end
      if (!restart && m_mode == 0 && m_run == 1) restart = 1'b1;
      if (restart) begin
         m_mode = 1;
         m_left = RC;
         m_cnt  = 0;
         for (int i = 0; i < 4; i++) m_ac[i] = old_sh[i];
      end else if (m_mode == 1) begin
         m_left = m_left - 1;
         if (m_left == 0) m_mode = (m_run == 1) ? 2 : 0;
      end else if (m_mode == 2 && m_run == 0) begin
         m_mode = 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_thr"}, 32'(neuron_threshold), 32'(m_ac[0]));
      chk({tag, "_dec"}, 32'(neuron_decay), 32'(m_ac[1]));
      chk({tag, "_ref"}, 32'(neuron_refractory), 32'(m_ac[2]));
      chk({tag, "_fbs"}, 32'(neuron_feedback), 32'(m_ac[3]));
      chk({tag, "_nrst"}, 32'(neuron_reset), 32'(m_mode == 1));
      chk({tag, "_en"}, 32'(neuron_enable), 32'(m_mode == 2));
      chk({tag, "_running"}, 32'(running), 32'(m_mode == 2));
      chk({tag, "_rdy"}, 32'(wr_ready), 32'(m_mode != 1));
      chk({tag, "_cur"}, 32'(neuron_current), 32'((m_mode == 2) ? m_cur : 0));
      chk({tag, "_cnt"}, 32'(spike_count), 32'(CNT_ON ? m_cnt : 0));
   endtask

   task automatic tick(input bit v, input int a, input int d, input bit s, input string tag);
      wr_valid = v;
      wr_addr  = 3'(a);
      wr_data  = 8'(d);
      spike_in = s;
      @(posedge clk);
      model_step(v, a, d, s);
      #1;
      check_all(tag);
   endtask

   typedef struct {
      bit   v;
      int   a;
      int   d;
      bit   s;
      int   e_thr;
      bit   e_nrst;
      bit   e_en;
      int   e_cur;
      bit   e_rdy;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{1'b1, 0, 30,   1'b0, 50, 1'b0, 1'b0, 0,  1'b1};
      tbl[1] = '{1'b0, 0, 0,    1'b0, 50, 1'b0, 1'b0, 0,  1'b1};
      tbl[2] = '{1'b1, 4, 8'h04,1'b0, 30, 1'b0, 1'b0, 0,  1'b1};
      tbl[3] = '{1'b1, 5, 60,   1'b0, 30, 1'b0, 1'b0, 0,  1'b1};
      tbl[4] = '{1'b1, 4, 8'h01,1'b0, 30, 1'b1, 1'b0, 0,  1'b0};
      tbl[5] = '{1'b0, 0, 0,    1'b0, 30, 1'b1, 1'b0, 0,  1'b0};
      tbl[6] = '{1'b0, 0, 0,    1'b0, 30, 1'b0, 1'b1, 60, 1'b1};
      tbl[7] = '{1'b0, 0, 0,    1'b0, 30, 1'b0, 1'b1, 60, 1'b1};

      // Power-on reset.
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_all("por");
      chk("por_thr50", 32'(neuron_threshold), 32'd50);
      chk("por_dec10", 32'(neuron_decay), 32'd10);
      chk("por_ref5", 32'(neuron_refractory), 32'd5);
      chk("por_fbs20", 32'(neuron_feedback), 32'd20);
      reset = 1'b0;

      // Directed vector table: commit semantics and start-up pulse.
      for (int i = 0; i < 8; i++) begin
         tick(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s, "tbl");
         chk("tbl_thr_c", 32'(neuron_threshold), 32'(tbl[i].e_thr));
         chk("tbl_nrst_c", 32'(neuron_reset), 32'(tbl[i].e_nrst));
         chk("tbl_en_c", 32'(neuron_enable), 32'(tbl[i].e_en));
         chk("tbl_cur_c", 32'(neuron_current), 32'(tbl[i].e_cur));
         chk("tbl_rdy_c", 32'(wr_ready), 32'(tbl[i].e_rdy));
      end

      // Seven spikes in RUN.
      for (int i = 0; i < 7; i++) tick(1'b0, 0, 0, 1'b1, "spk");
      tick(1'b0, 0, 0, 1'b0, "spk");
      chk("cnt7", 32'(spike_count), CNT_ON ? 32'd7 : 32'd0);

      // Soft reset while running: count clears, pulse, back to RUN.
      tick(1'b1, 4, 8'h03, 1'b1, "srst");
      chk("srst_cnt0", 32'(spike_count), 32'd0);
      chk("srst_nrst", 32'(neuron_reset), 32'd1);
      tick(1'b0, 0, 0, 1'b1, "srst");
      tick(1'b0, 0, 0, 1'b0, "srst");
      chk("srst_back_run", 32'(neuron_enable), 32'd1);

      // Saturation.
      for (int i = 0; i < 20; i++) tick(1'b0, 0, 0, 1'b1, "sat");
      chk("cnt_sat", 32'(spike_count), CNT_ON ? 32'(CMAX) : 32'd0);

      // Stop: disable and zero current next cycle, count held in IDLE.
      tick(1'b1, 4, 8'h00, 1'b1, "stop");
      chk("stop_en", 32'(neuron_enable), 32'd0);
      chk("stop_cur", 32'(neuron_current), 32'd0);
      tick(1'b0, 0, 0, 1'b1, "stop");
      chk("stop_cnt_held", 32'(spike_count), CNT_ON ? 32'(CMAX) : 32'd0);

      // Soft reset with run=0, write held across the pulse must land afterwards.
      tick(1'b1, 4, 8'h02, 1'b0, "srst0");
      chk("srst0_rdy", 32'(wr_ready), 32'd0);
      tick(1'b1, 0, 77, 1'b0, "hold");
      tick(1'b1, 0, 77, 1'b0, "hold");
      chk("hold_idle", 32'(neuron_enable), 32'd0);
      tick(1'b1, 0, 77, 1'b0, "hold");
      tick(1'b1, 4, 8'h04, 1'b0, "hold");
      chk("hold_commit", 32'(neuron_threshold), 32'd77);

      // Async reset in the middle of the reset pulse.
      tick(1'b1, 4, 8'h01, 1'b0, "mid");
      wr_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all("arst");
      chk("arst_thr", 32'(neuron_threshold), 32'd50);
      chk("arst_nrst", 32'(neuron_reset), 32'd0);
      chk("arst_rdy", 32'(wr_ready), 32'd1);
      #2 reset = 1'b0;

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         bit v;
         int a;
         int d;
         v = ($urandom % 3) != 0;
         a = $urandom % 8;
         d = $urandom % 256;
         if (a == 4) d = (($urandom % 8) == 0 ? 2 : 0) + (($urandom % 3) == 0 ? 4 : 0)
                         + (($urandom % 4) != 0 ? 1 : 0);
         tick(v, a, d, ($urandom % 2) == 1, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
